// File: rtl/regfile_mport.sv
// Multi-port lane-masked vector register file with write-first bypass and a
// per-register pending scoreboard used by issue to stall on in-flight results.
module regfile_mport #(
   parameter int NUM_REGS   = 16,
   parameter int REG_WIDTH  = 288,
   parameter int LANE_WIDTH = 18,
   parameter int N_READ     = 2,
   parameter int N_WRITE    = 2,
   parameter int ZERO_REG   = 0,
   localparam int ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   localparam int LANES     = REG_WIDTH / LANE_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_READ*ADDR_W-1:0]      rd_addr,
   output logic [N_READ*REG_WIDTH-1:0]   rd_data,
   output logic [N_READ-1:0]             rd_busy,
   input  logic [N_WRITE-1:0]            wr_en,
   input  logic [N_WRITE*ADDR_W-1:0]     wr_addr,
   input  logic [N_WRITE*LANES-1:0]      wr_lane_mask,
   input  logic [N_WRITE*REG_WIDTH-1:0]  wr_data,
   input  logic                          rsv_en,
   input  logic [ADDR_W-1:0]             rsv_addr,
   output logic                          rsv_conflict
);

   logic [REG_WIDTH-1:0]         regs     [NUM_REGS];
   logic [REG_WIDTH-1:0]         regs_nxt [NUM_REGS];
   logic [NUM_REGS-1:0]          pending;
   logic [NUM_REGS-1:0]          pending_nxt;
   logic [NUM_REGS-1:0]          wr_hit;
   logic [N_READ*REG_WIDTH-1:0]  rd_data_nxt;
   logic [N_READ-1:0]            rd_busy_nxt;
   logic                         rsv_ok;
   logic                         conflict_nxt;

   // Addresses beyond the array, and r0 when hardwired to zero, hold no state.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      addr_ok = (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Ascending port order lets the highest-index port win each contended lane.
   always_comb begin
      wr_hit = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_nxt[r] = regs[r];
         for (int w = 0; w < N_WRITE; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r)) && addr_ok(ADDR_W'(r))) begin
               wr_hit[r] = 1'b1;
               for (int l = 0; l < LANES; l++) begin
                  if (wr_lane_mask[w*LANES + l])
                     regs_nxt[r][l*LANE_WIDTH +: LANE_WIDTH] =
                        wr_data[w*REG_WIDTH + l*LANE_WIDTH +: LANE_WIDTH];
               end
            end
         end
      end
   end

   always_comb begin
      rsv_ok       = rsv_en && addr_ok(rsv_addr);
      pending_nxt  = pending & ~wr_hit;
      conflict_nxt = 1'b0;
      if (rsv_ok) begin
         pending_nxt[rsv_addr] = 1'b1;
         conflict_nxt          = pending[rsv_addr] & ~wr_hit[rsv_addr];
      end
   end

   // Reads see the post-edge array and scoreboard, giving write-first bypass.
   always_comb begin
      rd_data_nxt = '0;
      rd_busy_nxt = '0;
      for (int p = 0; p < N_READ; p++) begin
         if (addr_ok(rd_addr[p*ADDR_W +: ADDR_W])) begin
            rd_data_nxt[p*REG_WIDTH +: REG_WIDTH] = regs_nxt[rd_addr[p*ADDR_W +: ADDR_W]];
            rd_busy_nxt[p]                        = pending_nxt[rd_addr[p*ADDR_W +: ADDR_W]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++)
            regs[r] <= '0;
         pending      <= '0;
         rd_data      <= '0;
         rd_busy      <= '0;
         rsv_conflict <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++)
            regs[r] <= regs_nxt[r];
         pending      <= pending_nxt;
         rd_data      <= rd_data_nxt;
         rd_busy      <= rd_busy_nxt;
         rsv_conflict <= conflict_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_mport.sv
// Bench for regfile_mport: directed scenarios plus random traffic, checked against an
// array-level reference model for both a plain instance and a hardwired-zero-r0 instance.
module tb_regfile_mport;

   localparam int RW = 288;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   rd_addr;
   logic [575:0] rd_data, z_rd_data;
   logic [1:0]   rd_busy, z_rd_busy;
   logic [1:0]   wr_en;
   logic [7:0]   wr_addr;
   logic [31:0]  wr_lane_mask;
   logic [575:0] wr_data;
   logic         rsv_en;
   logic [3:0]   rsv_addr;
   logic         rsv_conflict, z_rsv_conflict;

   int n_tests = 0;
   int n_fail  = 0;

   logic [RW-1:0] m_regs [2][16];
   bit            m_pend [2][16];
   logic [RW-1:0] e_data [2][2];
   bit            e_busy [2][2];
   bit            e_conf [2];

   always #5 clk = ~clk;

   regfile_mport u_dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_mask(wr_lane_mask), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_conflict(rsv_conflict)
   );

   regfile_mport #(.ZERO_REG(1)) u_dut_z (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(rd_addr), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_mask(wr_lane_mask), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_conflict(z_rsv_conflict)
   );

   function automatic bit ok(int k, int a);
      return !(k == 1 && a == 0);
   endfunction

   function automatic logic [RW-1:0] rnd288();
      logic [RW-1:0] v;
      for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 16; r++) begin
            m_regs[k][r] = '0;
            m_pend[k][r] = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            e_data[k][p] = '0;
            e_busy[k][p] = 1'b0;
         end
         e_conf[k] = 1'b0;
      end
   endtask

   // Applies this cycle's inputs to the architectural state and derives what the
   // read ports and conflict flag must show after the coming edge.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit clr [16];
         for (int r = 0; r < 16; r++) begin
            clr[r] = 1'b0;
            if (ok(k, r)) begin
               for (int w = 0; w < 2; w++)
                  if (wr_en[w] && int'(wr_addr[w*4 +: 4]) == r) clr[r] = 1'b1;
               for (int l = 0; l < 16; l++) begin
                  for (int w = 1; w >= 0; w--) begin
                     if (wr_en[w] && int'(wr_addr[w*4 +: 4]) == r && wr_lane_mask[w*16 + l]) begin
                        m_regs[k][r][l*18 +: 18] = wr_data[w*RW + l*18 +: 18];
                        break;
                     end
                  end
               end
            end
         end
         e_conf[k] = rsv_en && ok(k, int'(rsv_addr)) && m_pend[k][rsv_addr] && !clr[rsv_addr];
         for (int r = 0; r < 16; r++)
            m_pend[k][r] = (m_pend[k][r] && !clr[r]) || (rsv_en && int'(rsv_addr) == r && ok(k, r));
         for (int p = 0; p < 2; p++) begin
            int a;
            a = int'(rd_addr[p*4 +: 4]);
            e_data[k][p] = ok(k, a) ? m_regs[k][a] : '0;
            e_busy[k][p] = ok(k, a) ? m_pend[k][a] : 1'b0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s_i%0d_p%0d_data", tag, k, p),
                (k == 0) ? rd_data[p*RW +: RW] : z_rd_data[p*RW +: RW], e_data[k][p]);
            chk($sformatf("%s_i%0d_p%0d_busy", tag, k, p),
                RW'((k == 0) ? rd_busy[p] : z_rd_busy[p]), RW'(e_busy[k][p]));
         end
         chk($sformatf("%s_i%0d_conflict", tag, k),
             RW'((k == 0) ? rsv_conflict : z_rsv_conflict), RW'(e_conf[k]));
      end
   endtask

   task automatic idle();
      rd_addr      = '0;
      wr_en        = '0;
      wr_addr      = '0;
      wr_lane_mask = '0;
      wr_data      = '0;
      rsv_en       = 1'b0;
      rsv_addr     = '0;
   endtask

   task automatic set_wr(input int w, input int a, input logic [15:0] mask, input logic [RW-1:0] d);
      wr_en[w]               = 1'b1;
      wr_addr[w*4 +: 4]      = 4'(a);
      wr_lane_mask[w*16 +: 16] = mask;
      wr_data[w*RW +: RW]    = d;
   endtask

   task automatic rsv(input int a);
      rsv_en   = 1'b1;
      rsv_addr = 4'(a);
   endtask

   task automatic cyc(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_clear();
      #3;
      check_all("reset");
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-register write then read of a written and an untouched register.
      set_wr(0, 15, 16'hFFFF, 288'd2);
      cyc("t1w");
      rd_addr = {4'd15, 4'd14};
      cyc("t1r");
      chk("t1_rdA", rd_data[0 +: RW], '0);
      chk("t1_rdB", rd_data[RW +: RW], 288'd2);
      chk("t1_busy", RW'(rd_busy), '0);

      // Two ports hit the same register; port 1 owns lane 0 only.
      set_wr(0, 3, 16'hFFFF, {16{18'h00001}});
      set_wr(1, 3, 16'h0001, {16{18'h3FFFF}});
      rd_addr = {4'd0, 4'd3};
      cyc("t2");
      chk("t2_merge", rd_data[0 +: RW], {{15{18'h00001}}, 18'h3FFFF});

      // Read during an overwrite must return the new value.
      set_wr(0, 5, 16'hFFFF, {16{18'h00123}});
      cyc("t3a");
      set_wr(1, 5, 16'hFFFF, {16{18'h00ABC}});
      rd_addr = {4'd5, 4'd5};
      cyc("t3b");
      chk("t3_bypass", rd_data[0 +: RW], {16{18'h00ABC}});

      // Scoreboard: reserve, re-reserve, complete, reserve+complete together.
      rsv(7);
      cyc("t4a");
      rd_addr = {4'd0, 4'd7};
      rsv(7);
      cyc("t4b");
      chk("t4_busy_set", RW'(rd_busy[0]), 288'd1);
      chk("t4_conflict", RW'(rsv_conflict), 288'd1);
      rd_addr = {4'd0, 4'd7};
      cyc("t4c");
      chk("t4_conflict_drop", RW'(rsv_conflict), '0);
      set_wr(0, 7, 16'hFFFF, rnd288());
      rd_addr = {4'd0, 4'd7};
      cyc("t4d");
      chk("t4_busy_clr", RW'(rd_busy[0]), '0);
      rsv(7);
      cyc("t4e");
      rsv(7);
      set_wr(1, 7, 16'h0000, rnd288());
      rd_addr = {4'd0, 4'd7};
      cyc("t4f");
      chk("t4_rsv_wr_busy", RW'(rd_busy[0]), 288'd1);
      chk("t4_rsv_wr_conf", RW'(rsv_conflict), '0);

      // r0 behaviour: ordinary in the plain instance, hardwired in the zero instance.
      set_wr(0, 0, 16'hFFFF, 288'h55);
      rsv(0);
      cyc("t5a");
      rsv(0);
      rd_addr = {4'd0, 4'd0};
      cyc("t5b");
      chk("t5_z_data", z_rd_data[0 +: RW], '0);
      chk("t5_z_busy", RW'(z_rd_busy[0]), '0);
      chk("t5_z_conf", RW'(z_rsv_conflict), '0);
      chk("t5_data", rd_data[0 +: RW], 288'h55);
      chk("t5_conf", RW'(rsv_conflict), 288'd1);

      // Asynchronous reset mid-cycle with state present and writes in flight.
      set_wr(0, 1, 16'hFFFF, rnd288());
      set_wr(1, 2, 16'hFFFF, rnd288());
      cyc("t6a");
      set_wr(0, 3, 16'hFFFF, rnd288());
      set_wr(1, 4, 16'hFFFF, rnd288());
      rsv(2);
      cyc("t6b");
      rd_addr = {4'd3, 4'd2};
      cyc("t6c");
      #3 rst_n = 1'b0;
      #1;
      model_clear();
      check_all("t6_async");
      chk("t6_rd_async", rd_data[0 +: RW], '0);
      set_wr(0, 1, 16'hFFFF, rnd288());
      rsv(1);
      @(posedge clk);
      #1;
      check_all("t6_hold");
      #2 rst_n = 1'b1;
      idle();
      @(posedge clk);
      #1;
      rd_addr = {4'd2, 4'd1};
      cyc("t6_r12");
      chk("t6_r1", rd_data[0 +: RW], '0);
      rd_addr = {4'd4, 4'd3};
      cyc("t6_r34");
      chk("t6_r3", rd_data[0 +: RW], '0);

      // Random traffic; a narrow address window forces frequent collisions.
      for (int it = 0; it < 400; it++) begin
         int hi;
         hi = ($urandom_range(0, 1) == 0) ? 3 : 15;
         for (int w = 0; w < 2; w++) begin
            if ($urandom_range(0, 2) != 0) begin
               logic [15:0] m;
               case ($urandom_range(0, 3))
                  0:       m = 16'h0000;
                  1:       m = 16'hFFFF;
                  default: m = 16'($urandom);
               endcase
               set_wr(w, $urandom_range(0, hi), m, rnd288());
            end
         end
         if ($urandom_range(0, 1) == 0) rsv($urandom_range(0, hi));
         rd_addr = {4'($urandom_range(0, hi)), 4'($urandom_range(0, hi))};
         cyc("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
